// File: rtl/layer_scheduler.sv
// Sequential dense-layer evaluator: buffers one input vector, then runs every
// neuron through a single shared MAC fed from a 1-cycle-latency weight memory.
module layer_scheduler #(
    parameter int LAYER_DATA_WIDTH = 16,
    parameter int NEURON_WIDTH     = 4,
    parameter int NUM_NEURONS      = 3,
    parameter int B_BITS           = 16,
    localparam int AW = (NUM_NEURONS * (NEURON_WIDTH + 1) > 1) ?
                        $clog2(NUM_NEURONS * (NEURON_WIDTH + 1)) : 1,
    localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               activation_func,
    output logic                               busy,
    input  logic                               x_valid,
    output logic                               x_ready,
    input  logic signed [LAYER_DATA_WIDTH-1:0] x_data,
    output logic                               w_rd_en,
    output logic [AW-1:0]                      w_addr,
    input  logic signed [LAYER_DATA_WIDTH-1:0] w_data,
    output logic                               y_valid,
    input  logic                               y_ready,
    output logic signed [LAYER_DATA_WIDTH+7:0] y_data,
    output logic [IW-1:0]                      y_idx,
    output logic                               done
);
    localparam int W     = LAYER_DATA_WIDTH;
    localparam int CW    = $clog2(NEURON_WIDTH + 1);
    localparam int ACC_W = 2 * W + 8;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            r_k_d;
    logic [IW-1:0]            r_n;
    logic                     r_rd_d;
    logic                     r_relu;
    logic signed [W-1:0]      r_x [NEURON_WIDTH];
    logic signed [ACC_W-1:0]  r_acc;

    logic signed [W-1:0]      w_x_sel;
    logic signed [2*W-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_term;
    logic                     w_load_last;
    logic                     w_n_last;

    assign w_load_last = (r_cnt == CW'(NEURON_WIDTH - 1));
    assign w_n_last    = (r_n == IW'(NUM_NEURONS - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        x_ready      = 1'b0;
        w_rd_en      = 1'b0;
        y_valid      = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD: begin
                x_ready = 1'b1;
                if (x_valid && w_load_last) w_state_next = S_MAC;
            end
            S_MAC: begin
                w_rd_en = 1'b1;
                if (r_cnt == CW'(NEURON_WIDTH)) w_state_next = S_DRAIN;
            end
            S_DRAIN: w_state_next = S_OUT;
            S_OUT: begin
                y_valid = 1'b1;
                if (y_ready) w_state_next = w_n_last ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Input vector buffer: one register per lane, written by beat index.
    generate
        for (genvar gi = 0; gi < NEURON_WIDTH; gi++) begin : g_xbuf
            always_ff @(posedge clk) begin
                if (r_state == S_LOAD && x_valid && r_cnt == CW'(gi))
                    r_x[gi] <= x_data;
            end
        end
    endgenerate

    always_comb begin
        w_x_sel = '0;
        for (int i = 0; i < NEURON_WIDTH; i++)
            if (r_k_d == CW'(i)) w_x_sel = r_x[i];
    end

    assign w_prod = w_data * w_x_sel;
    // r_k_d tags the word arriving this cycle; the last word of a neuron is its bias.
    assign w_term = (r_k_d == CW'(NEURON_WIDTH)) ?
                    {{(ACC_W - B_BITS){w_data[B_BITS-1]}}, w_data[B_BITS-1:0]} :
                    {{8{w_prod[2*W-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_k_d  <= '0;
            r_n    <= '0;
            r_rd_d <= 1'b0;
            r_relu <= 1'b0;
            r_acc  <= '0;
        end else begin
            r_rd_d <= (r_state == S_MAC);
            r_k_d  <= r_cnt;
            if (r_rd_d) r_acc <= r_acc + w_term;
            case (r_state)
                S_IDLE: if (start) begin
                    r_relu <= activation_func;
                    r_cnt  <= '0;
                end
                S_LOAD: if (x_valid) begin
                    if (w_load_last) begin
                        r_cnt <= '0;
                        r_n   <= '0;
                        r_acc <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MAC: r_cnt <= (r_cnt == CW'(NEURON_WIDTH)) ? '0 : r_cnt + 1'b1;
                S_OUT: if (y_ready && !w_n_last) begin
                    r_n   <= r_n + 1'b1;
                    r_acc <= '0;
                end
                default: ;
            endcase
        end
    end

    assign w_addr  = (r_state == S_MAC) ?
                     AW'(r_n) * AW'(NEURON_WIDTH + 1) + AW'(r_cnt) : '0;
    assign y_idx   = (r_state == S_OUT) ? r_n : '0;
    assign y_data  = (r_state == S_OUT && !(r_relu && (r_acc[ACC_W-1] || r_acc == '0))) ?
                     r_acc[W+7:0] : '0;
endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: table of whole-layer vectors plus a
// hand-written reset-abort sequence; weight memory modelled with 1-cycle latency.
module tb_layer_scheduler;
    localparam int NW = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               activation_func = 1'b0;
    logic               busy;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic signed [15:0] x_data = '0;
    logic               w_rd_en;
    logic [3:0]         w_addr;
    logic signed [15:0] w_data;
    logic               y_valid;
    logic               y_ready = 1'b1;
    logic signed [23:0] y_data;
    logic [1:0]         y_idx;
    logic               done;

    logic signed [15:0] mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    layer_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .activation_func(activation_func),
        .busy(busy), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (w_rd_en) w_data <= mem[w_addr];

    typedef struct packed {
        logic              relu;
        logic              gaps;
        logic [3:0]        bp;
        logic              spam;
        logic [3:0][15:0]  x;
        logic [14:0][15:0] w;
        logic [2:0][23:0]  y;
    } vec_t;

    vec_t tv [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_n(input int c, input int n, input int a0, input int a1,
                         input int a2, input int a3, input int b);
        tv[c].w[n*5+0] = 16'(a0);
        tv[c].w[n*5+1] = 16'(a1);
        tv[c].w[n*5+2] = 16'(a2);
        tv[c].w[n*5+3] = 16'(a3);
        tv[c].w[n*5+4] = 16'(b);
    endtask

    task automatic set_x(input int c, input int a0, input int a1, input int a2, input int a3);
        tv[c].x[0] = 16'(a0);
        tv[c].x[1] = 16'(a1);
        tv[c].x[2] = 16'(a2);
        tv[c].x[3] = 16'(a3);
    endtask

    task automatic set_y(input int c, input int y0, input int y1, input int y2);
        tv[c].y[0] = 24'(y0);
        tv[c].y[1] = 24'(y1);
        tv[c].y[2] = 24'(y2);
    endtask

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < 15; i++) mem[i] = v.w[i];
        mem[15] = '0;
    endtask

    // Pulse start and stream the four activations; returns at the negedge
    // following acceptance of the last beat (first MAC cycle).
    task automatic feed(input vec_t v);
        start           = 1'b1;
        activation_func = v.relu;
        @(negedge clk);
        start           = 1'b0;
        activation_func = 1'b0;
        for (int b = 0; b < NW; b++) begin
            x_valid = 1'b1;
            x_data  = v.x[b];
            @(negedge clk);
            if (v.gaps && b < NW - 1) begin
                x_valid = 1'b0;
                x_data  = 16'h5A5A;
                @(negedge clk);
                check("gap_load", {x_ready, w_rd_en}, 2'b10);
            end
        end
        x_valid = 1'b0;
    endtask

    task automatic run_vec(input int c);
        vec_t v;
        int   lat, nres, done_cnt, post, bp_left;
        bit   seen;
        v = tv[c];
        load_mem(v);
        feed(v);
        check("mac_entry", {w_rd_en, w_addr}, {1'b1, 4'd0});
        lat = 1; nres = 0; done_cnt = 0; post = 0; seen = 0; bp_left = int'(v.bp);
        for (int cyc = 0; cyc < 200 && post < 3; cyc++) begin
            @(negedge clk);
            lat++;
            if (done) done_cnt++;
            if (nres == 3) post++;
            start = v.spam && (w_rd_en || y_valid);
            if (y_valid) begin
                if (!seen) begin
                    seen = 1;
                    check("latency", lat, NW + 3);
                end
                if (nres == 0 && bp_left > 0) begin
                    y_ready = 1'b0;
                    bp_left--;
                    check("bp_hold", {w_rd_en, y_idx, y_data}, {1'b0, 2'd0, v.y[0]});
                end else if (nres < 3) begin
                    y_ready = 1'b1;
                    $display("[TB] case %0d result idx=%0d y_data=%0d", c, y_idx, y_data);
                    check("y_data", {40'd0, y_data}, {40'd0, v.y[nres]});
                    check("y_idx", y_idx, nres);
                    nres++;
                end else begin
                    check("extra_result", 1, 0);
                end
            end
        end
        y_ready = 1'b1;
        start   = 1'b0;
        check("results", nres, 3);
        check("done_count", done_cnt, 1);
        check("idle_after", busy, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < 5; c++) tv[c] = '0;
        // 0: basic layer
        set_x(0, 1, 2, 3, 4);
        set_n(0, 0, 1, 1, 1, 1, 0);
        set_n(0, 1, -1, -1, -1, -1, 0);
        set_n(0, 2, 2, 0, 0, 0, -5);
        set_y(0, 10, -10, -3);
        // 1: same data, ReLU, with output backpressure on neuron 0
        tv[1] = tv[0];
        tv[1].relu = 1'b1;
        tv[1].bp   = 4'd5;
        set_y(1, 10, 0, 0);
        // 2: mixed signs, ReLU, gapped input stream
        set_x(2, 5, -3, 7, 0);
        set_n(2, 0, 2, 3, -1, 4, 100);
        set_n(2, 1, 0, 0, 0, 0, -1);
        set_n(2, 2, 1000, 1000, 1000, 1000, 0);
        set_y(2, 94, 0, 9000);
        tv[2].relu = 1'b1;
        tv[2].gaps = 1'b1;
        // 3: positive full-scale; acc>0 so ReLU passes the truncated (negative) slice
        set_x(3, 32767, 32767, 32767, 32767);
        for (int n = 0; n < 3; n++) set_n(3, n, 32767, 32767, 32767, 32767, 0);
        set_y(3, 24'hFC0004, 24'hFC0004, 24'hFC0004);
        tv[3].relu = 1'b1;
        tv[3].spam = 1'b1;
        // 4: negative full-scale, acc = 2^32 -> low 24 bits zero
        set_x(4, -32768, -32768, -32768, -32768);
        for (int n = 0; n < 3; n++) set_n(4, n, -32768, -32768, -32768, -32768, 0);
        set_y(4, 0, 0, 0);

        for (int i = 0; i < 16; i++) mem[i] = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, x_ready, w_rd_en, y_valid, done, y_data, y_idx, w_addr}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int c = 0; c < 5; c++) begin
            run_vec(c);
            @(negedge clk);
        end

        // Reset during neuron 1's MAC of the extreme vector
        begin
            bit got;
            int done_seen;
            got = 0;
            done_seen = 0;
            load_mem(tv[4]);
            feed(tv[4]);
            for (int cyc = 0; cyc < 50 && !got; cyc++) begin
                @(negedge clk);
                if (y_valid) got = 1;
            end
            check("wait_y0", got, 1'b1);
            check("ext_y0", {y_idx, y_data}, 26'd0);
            $display("[TB] reset seq result idx=%0d y_data=%0d", y_idx, y_data);
            @(negedge clk);
            check("n1_mac", {w_rd_en, w_addr}, {1'b1, 4'd5});
            repeat (2) @(negedge clk);
            check("n1_mac_mid", {w_rd_en, w_addr}, {1'b1, 4'd7});
            rst = 1'b1;
            @(negedge clk);
            check("rst_mid_mac", {busy, x_ready, w_rd_en, y_valid, done, y_data, y_idx, w_addr}, '0);
            rst   = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_after_rst", {busy, x_ready}, 2'b11);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(negedge clk);
                if (done || busy) done_seen++;
            end
            check("no_done_after_abort", done_seen, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter LAYER_DATA_WIDTH, default 16, meaning the width of input activations and weight words (signed).
REQ-002 SHALL have parameter NEURON_WIDTH, default 4, meaning the number of inputs per neuron.
REQ-003 SHALL have parameter NUM_NEURONS, default 3, meaning the number of neurons in the layer, evaluated sequentially on one shared MAC.
REQ-004 SHALL have parameter B_BITS, default 16, meaning the bias width, carried in the low B_BITS of a weight word.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port start, input, 1, a one-cycle request to evaluate a layer.
REQ-008 SHALL have port activation_func, input, 1, where 1 selects ReLU; sampled on the accepted start only.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have ports x_valid (input, 1), x_ready (output, 1) and x_data (input, LAYER_DATA_WIDTH signed), forming a serial input-vector stream.
REQ-011 SHALL have ports w_rd_en (output, 1), w_addr (output, clog2(NUM_NEURONS*(NUM_NEURONS... NEURON_WIDTH+1))) and w_data (input, LAYER_DATA_WIDTH signed), forming the weight memory read port with fixed 1-cycle read latency.
REQ-012 SHALL have ports y_valid (output, 1), y_ready (input, 1), y_data (output, LAYER_DATA_WIDTH+8 signed) and y_idx (output, clog2(NUM_NEURONS)), forming the neuron result stream.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse when the layer completes.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, MAC, DRAIN, OUT and DONE.
REQ-015 SHALL move IDLE->LOAD on start; start in any other state is ignored.
REQ-016 In LOAD, x_ready SHALL be 1; each x_valid&x_ready cycle stores x_data into x[cnt] and increments cnt; after the NEURON_WIDTH-th beat the FSM SHALL go to MAC with neuron index n=0.
REQ-017 On MAC entry the accumulator SHALL clear, and MAC SHALL last NEURON_WIDTH+1 cycles with k=0..NEURON_WIDTH, w_rd_en=1 and w_addr=n*(NEURON_WIDTH+1)+k.
REQ-018 The word returned for k<NEURON_WIDTH SHALL add w_data*x[k] to the accumulator; the word for k=NEURON_WIDTH is the bias, whose sign-extended w_data[B_BITS-1:0] SHALL be added.
REQ-019 The accumulator SHALL be LAYER_DATA_WIDTH*2+8 bits signed with no saturation; products are full 2*LAYER_DATA_WIDTH signed.
REQ-020 DRAIN SHALL be one cycle with w_rd_en=0 that absorbs the final (bias) read data, then goes to OUT.
REQ-021 In OUT, y_valid=1 and y_idx=n; y_data SHALL be 0 if ReLU is selected and acc<=0 (full-width compare), otherwise acc[LAYER_DATA_WIDTH+7:0].
REQ-022 y_data and y_idx SHALL be stable while y_valid=1 and y_ready=0.
REQ-023 On y_valid&y_ready, the FSM SHALL go to MAC with n+1 if n<NUM_NEURONS-1, otherwise to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE; the stored x[] is not reused across layers.
REQ-025 Latency SHALL be NEURON_WIDTH+2 cycles from MAC entry to y_valid; with y_ready held high, the first result appears NEURON_WIDTH+3 cycles after the last LOAD beat is accepted.
REQ-026 x_ready, w_rd_en and y_valid SHALL be 0 outside LOAD, MAC and OUT respectively.

Reset
REQ-027 When rst=1 at a clock edge the FSM SHALL enter IDLE, with busy, x_ready, w_rd_en, y_valid and done at 0, y_data, y_idx, w_addr, counters and the accumulator at 0, and the ReLU flag at 0.
REQ-028 Reset in any state, including mid-MAC or in OUT under backpressure, SHALL abort the layer with no done pulse; a start in the cycle after reset release SHALL be accepted.

Verification
REQ-029 Basic layer: x={1,2,3,4}; n0 w={1,1,1,1} b=0; n1 w={-1,-1,-1,-1} b=0; n2 w={2,0,0,0} b=-5; ReLU=0 -> y=10, -10, -3 with idx 0, 1, 2, then a single done pulse.
REQ-030 ReLU on with the same data -> y=10, 0, 0.
REQ-031 Backpressure: hold y_ready=0 for 5 cycles on n0 -> y_valid stays 1, y_data stays 10, no w_rd_en, then resumes correctly.
REQ-032 Input gaps: x_valid toggles 1,0,1,0 -> exactly 4 beats captured in order; MAC starts only after the 4th beat.
REQ-033 start pulsed during MAC and OUT -> ignored; results are unchanged and exactly one done.
REQ-034 Extremes: x=all -32768, w=all -32768, b=0 -> acc=2^32, y_data=acc[23:0]=0; then rst asserted mid-MAC of n1 -> all outputs 0 next cycle and no done.
